ccff_chain_loader: RTL and testbench

//  Configuration controller for one logic tile's configuration chain (ccff_head -> ccff_tail).

---
 rtl/ccff_chain_loader_pkg.sv | 28 ++
 rtl/ccff_crc16_serial.sv | 25 ++
 rtl/ccff_chain_loader.sv | 143 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - state encoding and CRC-16 constants for the config chain loader
package ccff_chain_loader_pkg;

  localparam logic [2:0] IDLE_ENC   = 3'd0;
  localparam logic [2:0] FETCH_ENC  = 3'd1;
  localparam logic [2:0] SHIFT_ENC  = 3'd2;
  localparam logic [2:0] VERIFY_ENC = 3'd3;
  localparam logic [2:0] DONE_ENC   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE_ENC,
    ST_FETCH  = FETCH_ENC,
    ST_SHIFT  = SHIFT_ENC,
    ST_VERIFY = VERIFY_ENC,
    ST_DONE   = DONE_ENC
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first bit-serial step, no reflection
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16 accumulator, one step per enabled cycle
module ccff_crc16_serial
  import ccff_chain_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic        i_bit_in,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_init) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_bit_in);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - streams host words serially into a tile config chain, optional CRC readback
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int DATA_W    = 8
) (
  input  logic              i_prog_clk,
  input  logic              i_prog_reset,
  input  logic              i_start,
  input  logic              i_verify_en,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_cfg_data,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  output logic              o_ccff_head,
  output logic              o_ccff_shift_en,
  input  logic              i_ccff_tail,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [15:0]       o_bit_count
);

  localparam int              WL_W      = $clog2(DATA_W + 1);
  localparam logic [15:0]     LAST_BIT  = 16'(CHAIN_LEN - 1);
  localparam logic [WL_W-1:0] FULL_WORD = WL_W'(DATA_W);

  state_t            r_state;
  logic [DATA_W-1:0] r_sreg;
  logic [WL_W-1:0]   r_word_left;
  logic [15:0]       r_bit_count;
  logic              r_verify;
  logic              r_error;

  logic [15:0]       w_remaining;
  logic [15:0]       w_crc_load;
  logic [15:0]       w_crc_rb;
  logic              w_crc_init;
  logic              w_verify_fail;

  assign w_remaining   = 16'(CHAIN_LEN) - r_bit_count;
  assign w_crc_init    = (r_state == ST_IDLE) && i_start;
  assign w_verify_fail = (r_state == ST_DONE) && r_verify && (w_crc_rb != w_crc_load);

  always_ff @(posedge i_prog_clk) begin
    if (i_prog_reset) begin
      r_state     <= ST_IDLE;
      r_sreg      <= '0;
      r_word_left <= '0;
      r_bit_count <= '0;
      r_verify    <= 1'b0;
      r_error     <= 1'b0;
    end else if (i_abort && (r_state != ST_IDLE)) begin
      r_state <= ST_IDLE;
      r_error <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_error     <= 1'b0;
            r_bit_count <= '0;
            r_verify    <= i_verify_en;
            r_state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (i_cfg_valid) begin
            r_sreg      <= i_cfg_data;
            // the final word is trimmed so surplus high bits are never shifted
            r_word_left <= (w_remaining < 16'(DATA_W)) ? w_remaining[WL_W-1:0] : FULL_WORD;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sreg      <= r_sreg >> 1;
          r_word_left <= r_word_left - WL_W'(1);
          if (r_bit_count == LAST_BIT) begin
            if (r_verify) begin
              r_bit_count <= '0;
              r_state     <= ST_VERIFY;
            end else begin
              r_bit_count <= r_bit_count + 16'd1;
              r_state     <= ST_DONE;
            end
          end else begin
            r_bit_count <= r_bit_count + 16'd1;
            if (r_word_left == WL_W'(1)) begin
              r_state <= ST_FETCH;
            end
          end
        end
        ST_VERIFY: begin
          r_bit_count <= r_bit_count + 16'd1;
          if (r_bit_count == LAST_BIT) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_error <= r_error | w_verify_fail;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // recirculating tail -> head leaves the chain unchanged after CHAIN_LEN shifts
  always_comb begin
    o_ccff_head = 1'b0;
    if (r_state == ST_SHIFT) begin
      o_ccff_head = r_sreg[0];
    end else if (r_state == ST_VERIFY) begin
      o_ccff_head = i_ccff_tail;
    end
  end

  assign o_cfg_ready     = (r_state == ST_FETCH);
  assign o_ccff_shift_en = (r_state == ST_SHIFT) || (r_state == ST_VERIFY);
  assign o_busy          = (r_state != ST_IDLE);
  assign o_done          = (r_state == ST_DONE);
  assign o_error         = r_error | w_verify_fail;
  assign o_bit_count     = r_bit_count;

  ccff_crc16_serial u_crc_load (
    .i_clk    (i_prog_clk),
    .i_rst    (i_prog_reset),
    .i_init   (w_crc_init),
    .i_en     (r_state == ST_SHIFT),
    .i_bit_in (r_sreg[0]),
    .o_crc    (w_crc_load)
  );

  ccff_crc16_serial u_crc_rb (
    .i_clk    (i_prog_clk),
    .i_rst    (i_prog_reset),
    .i_init   (w_crc_init),
    .i_en     (r_state == ST_VERIFY),
    .i_bit_in (i_ccff_tail),
    .o_crc    (w_crc_rb)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - self-checking bench for ccff_chain_loader with a behavioural chain model
module tb_ccff_chain_loader;

  localparam int CL = 20;
  localparam int DW = 8;
  localparam int NW = (CL + DW - 1) / DW;
  localparam int FLIP_POS = 5;

  typedef struct packed {
    logic            verify;
    logic [1:0]      gap_word;
    logic [3:0]      gap;
    logic            flip;
    logic [7:0]      abort_at;
    logic [7:0]      rst_at;
    logic            glitch;
    logic            exp_error;
    logic [2:0][7:0] w;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, start, verify_en, abort, cfg_valid;
  logic [DW-1:0] cfg_data;
  logic          cfg_ready, head, shift_en, tail, busy, done, error;
  logic [15:0]   bit_count;

  logic [CL-1:0] chain = '0;
  int            flip_req = 0;
  int            flip_ack = 0;
  int            checks = 0;
  int            errors = 0;
  logic          exp_err_now;
  vec_t          vecs[8];

  ccff_chain_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
    .i_prog_clk      (clk),
    .i_prog_reset    (rst),
    .i_start         (start),
    .i_verify_en     (verify_en),
    .i_abort         (abort),
    .i_cfg_data      (cfg_data),
    .i_cfg_valid     (cfg_valid),
    .o_cfg_ready     (cfg_ready),
    .o_ccff_head     (head),
    .o_ccff_shift_en (shift_en),
    .i_ccff_tail     (tail),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error),
    .o_bit_count     (bit_count)
  );

  always #5 clk = ~clk;

  // chain: bit 0 is next to head, bit CL-1 drives tail
  assign tail = chain[CL-1];

  always @(posedge clk) begin : chain_model
    logic [CL-1:0] c;
    c = chain;
    if (flip_ack != flip_req) begin
      c[FLIP_POS] = ~c[FLIP_POS];
      flip_ack <= flip_req;
    end
    if (shift_en) c = {c[CL-2:0], head};
    chain <= c;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // after n shifts, stream bit k sits at chain position n-1-k
  task automatic check_chain(input int n, input logic [2:0][7:0] w);
    logic [CL-1:0] exp_c, mask;
    exp_c = '0;
    mask  = '0;
    for (int k = 0; k < n; k++) begin
      exp_c[n-1-k] = w[k/DW][k%DW];
      mask[n-1-k]  = 1'b1;
    end
    chk("chain_contents", 32'(chain & mask), 32'(exp_c));
  endtask

  task automatic check_reset_outputs();
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_ccff_head", head, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_bit_count", bit_count, 0);
  endtask

  function automatic vec_t mkvec(input logic verify, input int gap_word, input int gap,
                                 input logic flip, input int abort_at, input int rst_at,
                                 input logic glitch, input logic exp_error, input logic [23:0] w);
    vec_t v;
    v.verify = verify;     v.gap_word = 2'(gap_word); v.gap = 4'(gap);
    v.flip = flip;         v.abort_at = 8'(abort_at); v.rst_at = 8'(rst_at);
    v.glitch = glitch;     v.exp_error = exp_error;   v.w = w;
    return v;
  endfunction

  task automatic run_load(input vec_t v);
    int idx = 0, shift_cnt = 0, done_cnt = 0, busy_cyc = 0, overlap = 0, gap_left, exp_busy;
    logic last_rdy = 1'b0, last_vld = 1'b0, stall, finished = 1'b0;
    logic aborted = 1'b0, resetted = 1'b0, glitched = 1'b0, glitch_chk = 1'b0, err_done = 1'b0;
    logic [15:0] bc_done = '0, glitch_bc = '0;
    gap_left = int'(v.gap);
    exp_busy = CL * (v.verify ? 2 : 1) + NW + int'(v.gap) + 1;
    chk("error_before_start", error, exp_err_now);
    @(negedge clk);
    start = 1'b1;
    verify_en = v.verify;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_bit_count", bit_count, 0);
    chk("start_clears_error", error, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cyc++;
      if (last_rdy && last_vld) idx++;
      if (shift_en) shift_cnt++;
      if (done) begin
        done_cnt++;
        err_done = error;
        bc_done = bit_count;
      end
      if (shift_en && cfg_ready) overlap++;
      if (glitch_chk) begin
        chk("start_while_busy_ignored", bit_count, 32'(glitch_bc) + 1);
        glitch_chk = 1'b0;
      end
      abort = 1'b0;
      start = 1'b0;
      if (v.abort_at != 0 && !aborted && shift_cnt == int'(v.abort_at)) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      if (v.rst_at != 0 && !resetted && shift_cnt == int'(v.rst_at)) begin
        rst = 1'b1;
        resetted = 1'b1;
      end
      if (v.glitch && !glitched && shift_cnt == 5 && shift_en) begin
        start = 1'b1;
        verify_en = ~v.verify;
        glitched = 1'b1;
        glitch_chk = 1'b1;
        glitch_bc = bit_count;
      end
      if (v.flip && shift_cnt == CL && shift_en && flip_ack == flip_req && v.verify
          && bit_count == 16'(CL - 1) && !aborted) begin
        flip_req++;
      end
      stall = (idx == int'(v.gap_word)) && cfg_ready && (gap_left > 0);
      if (stall) begin
        gap_left--;
        chk("stall_no_shift", shift_en, 0);
      end
      cfg_valid = (idx < NW) && !stall;
      cfg_data  = (idx < NW) ? v.w[idx] : '0;
      last_rdy = cfg_ready;
      last_vld = cfg_valid;
    end
    cfg_valid = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    chk("run_finished", finished, 1);
    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_shift_en", shift_en, 0);
      chk("abort_error", error, 1);
      chk("abort_no_done", done_cnt, 0);
      check_chain(int'(v.abort_at), v.w);
      exp_err_now = 1'b1;
    end else if (resetted) begin
      check_reset_outputs();
      chk("reset_no_done", done_cnt, 0);
      rst = 1'b0;
      exp_err_now = 1'b0;
    end else begin
      chk("done_once", done_cnt, 1);
      chk("error_at_done", err_done, v.exp_error);
      chk("bit_count_at_done", bc_done, CL);
      chk("shift_cycles", shift_cnt, CL * (v.verify ? 2 : 1));
      chk("busy_cycles", busy_cyc, exp_busy);
      chk("ready_shift_overlap", overlap, 0);
      chk("error_sticky", error, v.exp_error);
      if (!v.flip) check_chain(CL, v.w);
      exp_err_now = v.exp_error;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; verify_en = 1'b0; abort = 1'b0;
    cfg_valid = 1'b0; cfg_data = '0; exp_err_now = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    //             verify gw gap flip abort rst      glitch err  words {w2,w1,w0}
    vecs[0] = mkvec(1'b0, 0, 0, 1'b0, 0, 0,      1'b0, 1'b0, 24'h0F3CA5);
    vecs[1] = mkvec(1'b1, 0, 0, 1'b0, 0, 0,      1'b0, 1'b0, 24'h0F3CA5);
    vecs[2] = mkvec(1'b1, 0, 0, 1'b1, 0, 0,      1'b0, 1'b1, 24'h0F3CA5);
    vecs[3] = mkvec(1'b0, 1, 5, 1'b0, 0, 0,      1'b0, 1'b0, 24'h0F3CA5);
    vecs[4] = mkvec(1'b0, 0, 0, 1'b0, 9, 0,      1'b0, 1'b1, 24'h0F3CA5);
    vecs[5] = mkvec(1'b0, 0, 0, 1'b0, 0, 0,      1'b0, 1'b0, 24'h5A96C3);
    vecs[6] = mkvec(1'b1, 0, 0, 1'b0, 0, CL + 3, 1'b0, 1'b0, 24'h0F3CA5);
    vecs[7] = mkvec(1'b1, 2, 2, 1'b0, 0, 0,      1'b1, 1'b0, 24'hE17B42);

    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i]);
      repeat (2) @(negedge clk);
    end

    for (int i = 0; i < 12; i++) begin
      vec_t rv;
      rv = mkvec(1'($urandom), int'($urandom_range(0, NW - 1)), int'($urandom_range(0, 4)),
                 1'b0, 0, 0, 1'($urandom), 1'b0, 24'($urandom));
      run_load(rv);
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
